// File: rtl/botoes_pkg.sv
// Shared types and constants for the button conditioning block.
//   CNT_W          width of every cycle counter (large enough for the longest timing parameter)
//   cnt_t          counter type
//   canal_state_e  per-key debounce / repeat FSM states
//   BTN_*          bit positions of the keys on the PIO bus
//   cnt_sat_inc    saturating increment for cnt_t
package botoes_pkg;

  localparam int unsigned CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_REL
  } canal_state_e;

  localparam int unsigned BTN_SUBIR  = 0;
  localparam int unsigned BTN_DESCER = 1;
  localparam int unsigned BTN_ENTRAR = 2;
  localparam int unsigned BTN_VOLTAR = 3;

  // Counters stick at all-ones instead of wrapping back into a match window.
  function automatic cnt_t cnt_sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/botoes_debounce_if.sv
// Key bus between the raw board keys and the PIO exports.
//   btn_n_i        raw keys, 0 = pressed, asynchronous
//   btn_level_o    debounced state, 1 = pressed
//   btn_press_o    one-cycle pulse on accepted press
//   btn_release_o  one-cycle pulse on accepted release
//   btn_evt_o      stretched event level per press or repeat
// slave is the conditioning block, master is whoever drives keys and reads events.
interface botoes_debounce_if #(
  parameter int unsigned N_BTN = 4
) ();

  logic [N_BTN-1:0] btn_n_i;
  logic [N_BTN-1:0] btn_level_o;
  logic [N_BTN-1:0] btn_press_o;
  logic [N_BTN-1:0] btn_release_o;
  logic [N_BTN-1:0] btn_evt_o;

  modport master (
    output btn_n_i,
    input  btn_level_o,
    input  btn_press_o,
    input  btn_release_o,
    input  btn_evt_o
  );

  modport slave (
    input  btn_n_i,
    output btn_level_o,
    output btn_press_o,
    output btn_release_o,
    output btn_evt_o
  );

endinterface

// File: rtl/botao_canal.sv
// One key channel: 2-flop synchroniser, debounce / auto-repeat FSM and event stretcher.
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn_n          raw key, 0 = pressed
//   level          debounced state, 1 = pressed
//   press_pulse    one-cycle pulse on accepted press
//   release_pulse  one-cycle pulse on accepted release
//   evt_level      STRETCH-cycle level per press or repeat
// All outputs are registered, so a clean raw edge shows up 2 + DB_CYCLES + 1 cycles later.
module botao_canal
  import botoes_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 500_000,
  parameter int unsigned RPT_DELAY  = 25_000_000,
  parameter int unsigned RPT_PERIOD = 5_000_000,
  parameter int unsigned STRETCH    = 2_500_000,
  parameter bit          RPT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic evt_level
);

  localparam cnt_t DbLast        = cnt_t'(DB_CYCLES - 1);
  localparam cnt_t RptDelayLast  = cnt_t'(RPT_DELAY - 1);
  localparam cnt_t RptPeriodLast = cnt_t'(RPT_PERIOD - 1);
  localparam cnt_t StretchLoad   = cnt_t'(STRETCH);

  // Synchroniser resets to "released" so a key held through reset re-debounces.
  logic [1:0] sync_q;
  logic       p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign p = ~sync_q[1];

  canal_state_e state_q, state_d;
  cnt_t         cnt_q, cnt_d;
  logic         rpt_q, rpt_d;   // DB_REL came from REPEAT, so a bounce returns there
  logic         level_q, level_d;
  logic         press_q, press_d;
  logic         release_q, release_d;
  logic         evt_d;
  cnt_t         str_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_sat_inc(cnt_q);
    rpt_d   = rpt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (p) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!p) begin
          state_d = DB_REL;
          cnt_d   = '0;
          rpt_d   = 1'b0;
        end else if (RPT_EN && (cnt_q == RptDelayLast)) begin
          state_d = REPEAT;
          cnt_d   = '0;
        end
      end
      REPEAT: begin
        if (!p) begin
          state_d = DB_REL;
          cnt_d   = '0;
          rpt_d   = 1'b1;
        end else if (cnt_q == RptPeriodLast) begin
          cnt_d = '0;
        end
      end
      DB_REL: begin
        if (p) begin
          state_d = rpt_q ? REPEAT : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; results are registered below.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    evt_d     = 1'b0;
    level_d   = level_q;
    case (state_q)
      DB_PRESS: begin
        if (p && (cnt_q == DbLast)) begin
          press_d = 1'b1;
          evt_d   = 1'b1;
          level_d = 1'b1;
        end
      end
      HELD: begin
        if (p && RPT_EN && (cnt_q == RptDelayLast)) evt_d = 1'b1;
      end
      REPEAT: begin
        if (p && (cnt_q == RptPeriodLast)) evt_d = 1'b1;
      end
      DB_REL: begin
        if (!p && (cnt_q == DbLast)) begin
          release_d = 1'b1;
          level_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers and stretcher. Loading STRETCH into the registered counter keeps the
  // event level exactly STRETCH cycles wide and aligned with the press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      str_q     <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      if (evt_d) begin
        str_q <= StretchLoad;
      end else if (str_q != '0) begin
        str_q <= str_q - cnt_t'(1);
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign evt_level     = (str_q != '0);

endmodule

// File: rtl/botoes_debounce.sv
// Button conditioning stage ahead of the SoC PIO inputs (subir/descer/entrar/voltar).
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   bus            key bus (slave side): raw keys in; level, press, release and event out
// One independent botao_canal per key; RPT_MASK selects which keys auto-repeat.
// The interface instance must be built with the same N_BTN as this module.
module botoes_debounce
  import botoes_pkg::*;
#(
  parameter int unsigned      N_BTN      = 4,
  parameter int unsigned      DB_CYCLES  = 500_000,
  parameter int unsigned      RPT_DELAY  = 25_000_000,
  parameter int unsigned      RPT_PERIOD = 5_000_000,
  parameter logic [N_BTN-1:0] RPT_MASK   = N_BTN'(4'b0011),
  parameter int unsigned      STRETCH    = 2_500_000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  botoes_debounce_if.slave  bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_p;
  logic [N_BTN-1:0] evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_canal
    botao_canal #(
      .DB_CYCLES  (DB_CYCLES),
      .RPT_DELAY  (RPT_DELAY),
      .RPT_PERIOD (RPT_PERIOD),
      .STRETCH    (STRETCH),
      .RPT_EN     (RPT_MASK[i])
    ) u_canal (
      .clk           (clk_clk),
      .rst_n         (reset_reset_n),
      .btn_n         (bus.btn_n_i[i]),
      .level         (level[i]),
      .press_pulse   (press[i]),
      .release_pulse (release_p[i]),
      .evt_level     (evt[i])
    );
  end

  assign bus.btn_level_o   = level;
  assign bus.btn_press_o   = press;
  assign bus.btn_release_o = release_p;
  assign bus.btn_evt_o     = evt;

  // Events are not queued: a repeat arriving while the previous one is still stretched
  // would merge into one long level and the firmware would miss it.
  a_rpt_exceeds_stretch : assert property (
    @(posedge clk_clk) disable iff (!reset_reset_n) (RPT_PERIOD > STRETCH)
  );

endmodule

// File: tb/tb_botoes_debounce.sv
module tb_botoes_debounce;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  botoes_debounce_if #(.N_BTN(4)) bus ();

  botoes_debounce #(
    .N_BTN      (4),
    .DB_CYCLES  (8),
    .RPT_DELAY  (40),
    .RPT_PERIOD (16),
    .RPT_MASK   (4'b0011),
    .STRETCH    (4)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  logic       clr_req = 1'b0;
  logic [3:0] evt_prev = '0;
  int press_cnt[4], press_at[4], rel_cnt[4], rel_at[4];
  int evt_hi[4], rise_cnt[4], lvl_low[4];
  int rise1[16];
  int press_f, press_nz, rel_f, rel_nz;

  always @(negedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4; i++) begin
        press_cnt[i] <= 0; press_at[i] <= 0; rel_cnt[i] <= 0; rel_at[i] <= 0;
        evt_hi[i] <= 0; rise_cnt[i] <= 0; lvl_low[i] <= 0;
      end
      press_f <= 0; press_nz <= 0; rel_f <= 0; rel_nz <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.btn_press_o[i]) begin
          press_cnt[i] <= press_cnt[i] + 1;
          press_at[i]  <= cyc;
        end
        if (bus.btn_release_o[i]) begin
          rel_cnt[i] <= rel_cnt[i] + 1;
          rel_at[i]  <= cyc;
        end
        if (bus.btn_evt_o[i]) evt_hi[i] <= evt_hi[i] + 1;
        if (bus.btn_evt_o[i] && !evt_prev[i]) begin
          rise_cnt[i] <= rise_cnt[i] + 1;
          if (i == 1 && rise_cnt[1] < 16) rise1[rise_cnt[1]] <= cyc;
        end
        if (!bus.btn_level_o[i]) lvl_low[i] <= lvl_low[i] + 1;
      end
      if (bus.btn_press_o != 4'h0) press_nz <= press_nz + 1;
      if (bus.btn_press_o == 4'hF) press_f <= press_f + 1;
      if (bus.btn_release_o != 4'h0) rel_nz <= rel_nz + 1;
      if (bus.btn_release_o == 4'hF) rel_f <= rel_f + 1;
    end
    evt_prev <= bus.btn_evt_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clears the monitor; ends 1 time unit after a rising edge.
  task automatic clr();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int c0, c1, cb, r;

  initial begin
    rst_n = 1'b0;
    bus.btn_n_i = 4'hF;
    step(3);
    check("reset_outputs", {bus.btn_level_o, bus.btn_press_o, bus.btn_release_o, bus.btn_evt_o},
          32'd0);
    rst_n = 1'b1;
    step(5);

    // 1: entrar press/hold/release, no repeat.
    clr();
    c0 = cyc;
    bus.btn_n_i[2] = 1'b0;
    step(100);
    check("t1_press_count", press_cnt[2], 1);
    check("t1_press_latency", press_at[2] - c0, 11);
    check("t1_evt_width", evt_hi[2], 4);
    check("t1_evt_count", rise_cnt[2], 1);
    check("t1_level_held", bus.btn_level_o[2], 1'b1);
    check("t1_other_press", press_cnt[0] + press_cnt[1] + press_cnt[3], 0);
    clr();
    c1 = cyc;
    bus.btn_n_i[2] = 1'b1;
    step(20);
    check("t1_rel_count", rel_cnt[2], 1);
    check("t1_rel_latency", rel_at[2] - c1, 11);
    check("t1_level_released", bus.btn_level_o[2], 1'b0);

    // 2: subir bounces, then settles pressed.
    clr();
    for (int k = 0; k < 10; k++) begin
      bus.btn_n_i[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    check("t2_no_press_bounce", press_cnt[0], 0);
    c0 = cyc;
    bus.btn_n_i[0] = 1'b0;
    step(40);
    check("t2_press_count", press_cnt[0], 1);
    check("t2_press_latency", press_at[0] - c0, 11);
    bus.btn_n_i[0] = 1'b1;
    step(20);

    // 3: descer auto-repeat.
    clr();
    c0 = cyc;
    bus.btn_n_i[1] = 1'b0;
    step(120);
    bus.btn_n_i[1] = 1'b1;
    step(20);
    check("t3_press_count", press_cnt[1], 1);
    check("t3_evt_count", rise_cnt[1], 6);
    check("t3_first_evt", rise1[0] - c0, 11);
    check("t3_rpt_delay", rise1[1] - rise1[0], 40);
    for (int k = 2; k < 6; k++) begin
      check($sformatf("t3_rpt_period_%0d", k), rise1[k] - rise1[k-1], 16);
    end
    check("t3_rel_count", rel_cnt[1], 1);

    // 4: all keys together.
    clr();
    bus.btn_n_i = 4'h0;
    step(30);
    check("t4_press_all_cycles", press_f, 1);
    check("t4_press_any_cycles", press_nz, 1);
    bus.btn_n_i = 4'hF;
    step(20);
    check("t4_rel_all_cycles", rel_f, 1);
    check("t4_rel_any_cycles", rel_nz, 1);

    // 5: reset while voltar is held.
    clr();
    c0 = cyc;
    bus.btn_n_i[3] = 1'b0;
    step(12);
    check("t5_level_before_rst", bus.btn_level_o[3], 1'b1);
    check("t5_evt_before_rst", bus.btn_evt_o[3], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_async_reset",
          {bus.btn_level_o, bus.btn_press_o, bus.btn_release_o, bus.btn_evt_o}, 32'd0);
    clr();
    step(1);
    rst_n = 1'b1;
    r = cyc;
    step(20);
    check("t5_repress_count", press_cnt[3], 1);
    check("t5_repress_latency", press_at[3] - r, 11);
    bus.btn_n_i[3] = 1'b1;
    step(20);

    // 6: short release blip during HELD on descer.
    c0 = cyc;
    bus.btn_n_i[1] = 1'b0;
    step(20);
    clr();
    cb = cyc;
    bus.btn_n_i[1] = 1'b1;
    step(5);
    bus.btn_n_i[1] = 1'b0;
    step(55);
    check("t6_no_release", rel_cnt[1], 0);
    check("t6_level_kept", lvl_low[1], 0);
    check("t6_evt_count", rise_cnt[1], 1);
    check("t6_rpt_after_blip", rise1[0] - cb, 48);
    bus.btn_n_i[1] = 1'b1;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
